interrupt_request_unit: RTL
===========================

Name: interrupt_request_unit

Overview:
- Machine-mode interrupt source that drives the `interrupt_pending` / `interrupt_taken` handshake consumed by the global control unit.
- Owns the machine timer (mtime/mtimecmp), the software-interrupt latch and a registered external-interrupt sample.
- Arbitrates between enabled sources by priority, raises a single pending request, and reports the cause code of the interrupt actually taken.
- Sits beside the CSR unit, which supplies the enable bits and reads mip/mtime.

Parameters:
- TIMER_WIDTH, 64, width of mtime and mtimecmp.
- PRESCALE, 1, clock cycles per mtime increment (1..256).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- ext_irq  in  1  level external interrupt request
- sw_set  in  1  pulse: set software-interrupt latch
- sw_clear  in  1  pulse: clear software-interrupt latch
- mtimecmp_we  in  1  write strobe for mtimecmp
- mtimecmp_wdata  in  TIMER_WIDTH  new mtimecmp value
- mie_meie  in  1  machine external interrupt enable
- mie_msie  in  1  machine software interrupt enable
- mie_mtie  in  1  machine timer interrupt enable
- mstatus_mie  in  1  global machine interrupt enable
- interrupt_taken  in  1  gc acknowledgement: the pending interrupt has been taken
- interrupt_pending  out  1  request to gc
- interrupt_cause  out  4  exception code of the last taken interrupt (11 = MEI, 3 = MSI, 7 = MTI)
- mip  out  3  {meip, mtip, msip}, registered
- mtime  out  TIMER_WIDTH  current timer value

Behaviour:
- Reset values:
  - mtime = 0, prescale counter = 0, mtimecmp = all ones.
  - msip, meip and mtip = 0, so mip = 0.
  - interrupt_pending = 0, interrupt_cause = 0, state = IDLE.
- Timer:
  - Prescale counter counts 0..PRESCALE-1.
  - mtime increments by 1 in the cycle the counter is at PRESCALE-1; the counter then returns to 0.
  - mtime wraps from all-ones to 0 silently.
- mtimecmp: written on mtimecmp_we, taking effect next cycle.
- mtip: registered `mtime >= mtimecmp`. It updates one cycle after mtime or mtimecmp changes.
- msip latch:
  - sw_set sets it; sw_clear clears it.
  - Simultaneous sw_set and sw_clear: set wins.
- meip: ext_irq registered once, i.e. 1-cycle sample delay.
- Definitions:
  - enabled = {meip & mie_meie, mtip & mie_mtie, msip & mie_msie}.
  - req = |enabled & mstatus_mie.
- Priority: MEI > MSI > MTI. sel_code is the code of the highest-priority enabled bit.
- FSM (registered; interrupt_pending = (state == PENDING)):
  - IDLE -> PENDING when req.
  - PENDING -> IDLE when ~req and ~interrupt_taken (source withdrawn or disabled before being taken; no cause update).
  - PENDING -> TAKEN on interrupt_taken. The same edge latches interrupt_cause = sel_code evaluated that cycle. interrupt_taken takes priority over a simultaneous drop of req.
  - TAKEN -> IDLE when mstatus_mie == 0, i.e. trap entry has cleared MIE. interrupt_pending stays 0 while in TAKEN, whatever the source levels are.
- Latency:
  - Enabled source level to interrupt_pending = 1 cycle after mip updates.
  - ext_irq to interrupt_pending = 2 cycles.
  - interrupt_taken to interrupt_pending low = 1 cycle.
- interrupt_taken in IDLE or TAKEN is ignored (state and cause unchanged); simulation assertion fires.
- Source clearing:
  - The unit never clears sources itself.
  - msip is cleared only by sw_clear.
  - mtip is cleared only by a mtimecmp write or by wrap.
  - meip follows ext_irq.
- rst asserted in any state returns all state to reset values next cycle, including a pending or taken handshake mid-operation.

Test Plan:
- Reset, mie_mtie = 1, mstatus_mie = 1, mtimecmp write 5, PRESCALE = 1:
  - mtip rises on the cycle after mtime reaches 5.
  - interrupt_pending rises 1 cycle later.
  - Assert interrupt_taken -> interrupt_cause = 7, interrupt_pending = 0 next cycle.
- All three sources asserted and enabled together, then interrupt_taken -> cause = 11.
  - Drop mstatus_mie, raise it again with ext_irq = 0 -> pending again; taken -> cause = 3.
- sw_set and sw_clear in the same cycle -> msip = 1.
  - sw_clear alone next -> msip = 0.
  - If this happens while PENDING and no other source is enabled, pending falls with no cause change.
- In TAKEN with mstatus_mie held 1 and msip = 1 -> interrupt_pending stays 0 for 20 cycles.
  - Set mstatus_mie = 0 -> IDLE.
  - mstatus_mie = 1 -> pending re-asserts.
- PRESCALE = 4, mtime preset by 300 cycles of run -> mtime = 75.
  - With TIMER_WIDTH = 8, mtime wraps 255 -> 0 and mtip (mtimecmp = 200) falls after the wrap.
- rst asserted in PENDING and in TAKEN -> next cycle interrupt_pending = 0, mip = 0, mtime = 0, interrupt_cause = 0.
  - A spurious interrupt_taken in IDLE leaves the cause unchanged.

Source files
------------

// File: rtl/interrupt_request_unit.sv
// Machine-mode interrupt source: mtime/mtimecmp timer, software-interrupt latch, registered
// external sample, priority arbitration and the pending/taken handshake towards the gc.
module interrupt_request_unit #(
    parameter int unsigned TIMER_WIDTH = 64,
    parameter int unsigned PRESCALE    = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ext_irq,
    input  logic                   sw_set,
    input  logic                   sw_clear,
    input  logic                   mtimecmp_we,
    input  logic [TIMER_WIDTH-1:0] mtimecmp_wdata,
    input  logic                   mie_meie,
    input  logic                   mie_msie,
    input  logic                   mie_mtie,
    input  logic                   mstatus_mie,
    input  logic                   interrupt_taken,
    output logic                   interrupt_pending,
    output logic [3:0]             interrupt_cause,
    output logic [2:0]             mip,
    output logic [TIMER_WIDTH-1:0] mtime
);

    localparam int unsigned   PW           = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESCALE_MAX = PW'(PRESCALE - 1);
    localparam logic [3:0]    CODE_MEI     = 4'd11;
    localparam logic [3:0]    CODE_MSI     = 4'd3;
    localparam logic [3:0]    CODE_MTI     = 4'd7;

    typedef enum logic [1:0] {StIdle, StPending, StTaken} state_e;

    state_e                 state_q, state_d;
    logic [3:0]             cause_q, cause_d;
    logic [PW-1:0]          pre_cnt_q;
    logic [TIMER_WIDTH-1:0] mtime_q, mtimecmp_q;
    logic                   msip_q, mtip_q, meip_q;
    logic                   tick;
    logic [2:0]             enabled;
    logic                   req;
    logic [3:0]             sel_code;

    always_comb begin
        tick    = (pre_cnt_q == PRESCALE_MAX);
        enabled = {meip_q & mie_meie, mtip_q & mie_mtie, msip_q & mie_msie};
        req     = (|enabled) & mstatus_mie;
        // MEI > MSI > MTI
        if (enabled[2]) begin
            sel_code = CODE_MEI;
        end else if (enabled[0]) begin
            sel_code = CODE_MSI;
        end else if (enabled[1]) begin
            sel_code = CODE_MTI;
        end else begin
            sel_code = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt_q  <= '0;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            mtip_q     <= 1'b0;
            meip_q     <= 1'b0;
            msip_q     <= 1'b0;
            state_q    <= StIdle;
            cause_q    <= 4'd0;
        end else begin
            if (tick) begin
                pre_cnt_q <= '0;
                mtime_q   <= mtime_q + TIMER_WIDTH'(1);
            end else begin
                pre_cnt_q <= pre_cnt_q + PW'(1);
            end
            if (mtimecmp_we) begin
                mtimecmp_q <= mtimecmp_wdata;
            end
            mtip_q <= (mtime_q >= mtimecmp_q);
            meip_q <= ext_irq;
            // Set wins over a simultaneous clear.
            if (sw_set) begin
                msip_q <= 1'b1;
            end else if (sw_clear) begin
                msip_q <= 1'b0;
            end
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            StIdle: begin
                if (req) begin
                    state_d = StPending;
                end
            end
            StPending: begin
                if (interrupt_taken) begin
                    state_d = StTaken;
                    cause_d = sel_code;
                end else if (!req) begin
                    state_d = StIdle;
                end
            end
            StTaken: begin
                // Trap entry clears MIE; only then can a new request be raised.
                if (!mstatus_mie) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign interrupt_pending = (state_q == StPending);
    assign interrupt_cause   = cause_q;
    assign mip               = {meip_q, mtip_q, msip_q};
    assign mtime             = mtime_q;

    spurious_taken: assert property (@(posedge clk) disable iff (rst)
        interrupt_taken |-> (state_q == StPending))
        else $warning("interrupt_taken outside pending state ignored");

endmodule
